rfi_flagger: RTL and testbench
==============================

Name: rfi_flagger

Overview:
- Downstream of the RFI detection stage; consumes its per-channel integrated power and correlation words plus their valid strobe.
- Per channel, compares correlation against a programmable fraction of power.
- Keeps a per-channel saturating persistence counter with on/off hysteresis in block RAM.
- Emits a per-channel RFI flag stream and a per-frame count of flagged channels, used by the downstream mitigation/blanking logic.

Parameters:
- DIN_WIDTH, 18, width of pow_data/corr_data, signed two's complement.
- CHANNEL_ADDR, 9, log2 of channels per frame; must be >= 3.
- THRESH_WIDTH, 16, width of unsigned threshold factor.
- THRESH_POINT, 15, fractional bits of threshold factor.
- CNT_WIDTH, 4, width of per-channel persistence counter.
- DEBUG, 1, enables the warning output; 0 ties warning to 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pow_data  in  DIN_WIDTH  signed integrated power, one channel per valid.
- corr_data  in  DIN_WIDTH  signed integrated correlation, same channel as pow_data.
- din_valid  in  1  qualifies pow_data/corr_data.
- sync_in  in  1  high with the channel-0 valid sample of a frame.
- thresh  in  THRESH_WIDTH  unsigned threshold factor, UQ(THRESH_WIDTH,THRESH_POINT).
- on_cnt  in  CNT_WIDTH  counter level at or above which the flag sets.
- off_cnt  in  CNT_WIDTH  counter level at or below which the flag clears.
- clear  in  1  one-cycle pulse; clears all channel state.
- busy  out  1  high while the state RAM is being cleared.
- flag  out  1  RFI flag for the channel in flag_chan.
- flag_chan  out  CHANNEL_ADDR  channel index of flag.
- dout_valid  out  1  qualifies flag/flag_chan.
- frame_count  out  CHANNEL_ADDR+1  number of flagged channels in the last frame.
- frame_valid  out  1  one-cycle pulse with frame_count.
- warning  out  1  one-cycle pulse on a dropped input (DEBUG only).

Behaviour:
- Reset and clear:
  - rst high: all outputs 0; channel counter 0; frame accumulator 0; FSM enters CLEAR.
  - FSM states: CLEAR and RUN.
  - CLEAR writes {cnt=0, flag=0} to RAM addresses 0..2^CHANNEL_ADDR-1, one per cycle, with busy=1. It moves to RUN after the last address, so busy lasts exactly 2^CHANNEL_ADDR cycles after rst falls.
  - clear pulse in RUN: enters CLEAR from address 0, flushes the pipeline (in-flight samples produce no dout_valid), and zeroes the channel counter and frame accumulator.
  - clear during CLEAR restarts the sweep at address 0.
  - rst during CLEAR or RUN behaves as above; rst wins over clear.
- Input handling during CLEAR: din_valid is dropped (no RAM write, no output) and warning pulses 1 cycle later when DEBUG=1.
- Channel index:
  - Increments on each accepted din_valid and wraps 2^CHANNEL_ADDR-1 -> 0.
  - sync_in with din_valid forces that sample to channel 0; counting continues from 1.
  - sync_in without din_valid is ignored.
- Pipeline (fixed latency 3 cycles, din_valid -> dout_valid; back-to-back valids fully supported):
  - S0: register inputs and channel index; issue RAM read.
  - S1: prod = pow_data * thresh (signed x unsigned, full width DIN_WIDTH+THRESH_WIDTH+1); lim = prod >>> THRESH_POINT, arithmetic shift. RAM data returns.
  - S2: exceed = (corr_data sign-extended) > lim, strictly greater; negative corr never exceeds when pow >= 0.
    - Counter update: exceed -> cnt+1, saturating at 2^CNT_WIDTH-1; else cnt-1, saturating at 0.
    - Flag update: new_flag = 1 if cnt_new >= on_cnt; 0 if cnt_new <= off_cnt; else old flag.
    - If on_cnt <= off_cnt, the set rule has priority.
    - Write {cnt_new, new_flag} back to the same address.
  - S3: registered flag, flag_chan, dout_valid.
- RAM hazard: same-channel accesses are >= 8 cycles apart (CHANNEL_ADDR >= 3), so no forwarding is required.
- Frame statistics:
  - Accumulator adds new_flag for every output.
  - When the output channel is 2^CHANNEL_ADDR-1, frame_count = accumulator including that channel, frame_valid pulses in the same cycle as that dout_valid, and the accumulator reset to 0.
  - A sync_in mid-frame does not emit frame_valid for the partial frame; the accumulator restarts at that channel-0 sample.
- thresh, on_cnt and off_cnt are sampled every cycle. Changes take effect on samples entering S1/S2 afterwards; no glitch protection is provided.

Decomposition:
- Package rfi_flag_pkg: FSM state enum {CLEAR, RUN}; RAM word layout (CNT_WIDTH+1 bits, flag in MSB); pipeline latency constant 3.
- Sub-module rfi_state_ram: simple dual-port RAM, depth 2^CHANNEL_ADDR, width CNT_WIDTH+1, 1-cycle registered read, write-first not required.

Test Plan:
- Reset: rst for 2 cycles, CHANNEL_ADDR=3 -> busy high exactly 8 cycles; all outputs 0; din_valid during busy -> warning pulse, no dout_valid.
- Threshold compare: thresh=0x4000 (0.5), pow=1000, corr=500 -> flag stays 0, counter not incremented; corr=501 -> counter increments.
- Hysteresis: on_cnt=3, off_cnt=1, channel 2 exceeds for 3 frames -> flag=1 on frame 3. Channel 2 then below for 1 frame -> flag stays 1 (cnt=2); below for 2 frames -> flag=0. Other channels stay 0.
- Saturation: CNT_WIDTH=4, exceed 20 frames -> cnt saturates at 15; then 14 below-frames with off_cnt=1 -> flag clears at the frame where cnt reaches 1.
- Frame count and sync: channels 1,4,7 flagged, 8 channels -> frame_valid with frame_count=3 coincident with flag_chan=7. sync_in at channel 5 -> next sample flag_chan=0, no frame_valid for the truncated frame.
- Clear mid-stream: clear pulse with 2 samples in flight -> those samples produce no dout_valid; busy for 8 cycles; all flags read 0 on the next frame.

Source files
------------

// File: rtl/rfi_flag_pkg.sv
// Shared definitions for the RFI flagger slice.
//   state_t        : state-RAM maintenance FSM (sweep-clear / normal run)
//   PIPE_LATENCY   : clock edges from the edge sampling din_valid to dout_valid
//   word_width()   : width of a state-RAM word, laid out as {flag, cnt}
//   next_flag()    : hysteresis rule applied to an updated persistence count
package rfi_flag_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned PIPE_LATENCY = 3;

  // RAM word: flag in the MSB, persistence counter in the low cnt_width bits.
  function automatic int word_width(input int cnt_width);
    return cnt_width + 1;
  endfunction

  // Set has priority over clear so that on_lvl <= off_lvl still flags.
  function automatic logic next_flag(input int unsigned cnt,
                                     input int unsigned on_lvl,
                                     input int unsigned off_lvl,
                                     input logic        old_flag);
    if (cnt >= on_lvl) begin
      return 1'b1;
    end else if (cnt <= off_lvl) begin
      return 1'b0;
    end
    return old_flag;
  endfunction

endpackage

// File: rtl/rfi_state_ram.sv
// Per-channel state RAM: simple dual-port, one write port and one read port,
// registered read with one cycle latency. No read/write collision handling.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, valid the cycle after raddr is presented
module rfi_state_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rfi_flagger.sv
// RFI flagger: per channel, flags RFI when correlation exceeds a programmable
// fraction of integrated power, filtered by a saturating persistence counter
// with on/off hysteresis held in block RAM. Also counts flagged channels per
// frame.
//   clk, rst           : clock, synchronous active-high reset
//   pow_data/corr_data : signed power / correlation for one channel
//   din_valid, sync_in : input strobe; sync_in marks channel 0 of a frame
//   thresh             : UQ threshold factor applied to power
//   on_cnt/off_cnt     : counter levels that set / clear the flag
//   clear              : pulse, wipes all channel state
//   busy               : state RAM sweep in progress, inputs dropped
//   flag, flag_chan    : per-channel result, qualified by dout_valid
//   frame_count        : flagged channels in last frame, with frame_valid
//   warning            : pulse after a dropped input (DEBUG builds)
module rfi_flagger
  import rfi_flag_pkg::*;
#(
  parameter int DIN_WIDTH    = 18,
  parameter int CHANNEL_ADDR = 9,
  parameter int THRESH_WIDTH = 16,
  parameter int THRESH_POINT = 15,
  parameter int CNT_WIDTH    = 4,
  parameter int DEBUG        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_WIDTH-1:0]    pow_data,
  input  logic [DIN_WIDTH-1:0]    corr_data,
  input  logic                    din_valid,
  input  logic                    sync_in,
  input  logic [THRESH_WIDTH-1:0] thresh,
  input  logic [CNT_WIDTH-1:0]    on_cnt,
  input  logic [CNT_WIDTH-1:0]    off_cnt,
  input  logic                    clear,
  output logic                    busy,
  output logic                    flag,
  output logic [CHANNEL_ADDR-1:0] flag_chan,
  output logic                    dout_valid,
  output logic [CHANNEL_ADDR:0]   frame_count,
  output logic                    frame_valid,
  output logic                    warning
);

  localparam int PROD_WIDTH = DIN_WIDTH + THRESH_WIDTH + 1;
  localparam int WORD_WIDTH = word_width(CNT_WIDTH);
  localparam int FC_WIDTH   = CHANNEL_ADDR + 1;

  state_t                    state;
  logic [CHANNEL_ADDR-1:0]   clr_addr;
  logic [CHANNEL_ADDR-1:0]   chan_cnt;
  logic [CHANNEL_ADDR-1:0]   in_chan;
  logic                      accept;

  logic                         s0_valid;
  logic signed [DIN_WIDTH-1:0]  s0_pow;
  logic signed [DIN_WIDTH-1:0]  s0_corr;
  logic [CHANNEL_ADDR-1:0]      s0_chan;

  logic                         s1_valid;
  logic signed [PROD_WIDTH-1:0] s1_lim;
  logic signed [DIN_WIDTH-1:0]  s1_corr;
  logic [CHANNEL_ADDR-1:0]      s1_chan;

  logic                         s2_valid;
  logic [CHANNEL_ADDR-1:0]      s2_chan;
  logic [CNT_WIDTH-1:0]         s2_cnt;
  logic                         s2_flag;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] lim;
  logic signed [PROD_WIDTH-1:0] corr_ext;
  logic                         exceed;
  logic [CNT_WIDTH-1:0]         old_cnt;
  logic                         old_flag;
  logic [CNT_WIDTH-1:0]         cnt_new;
  logic                         new_flag;

  logic [FC_WIDTH-1:0]          acc;
  logic [FC_WIDTH-1:0]          frame_sum;

  logic                         ram_we;
  logic [CHANNEL_ADDR-1:0]      ram_waddr;
  logic [WORD_WIDTH-1:0]        ram_wdata;
  logic [WORD_WIDTH-1:0]        ram_rdata;

  assign accept  = din_valid && (state == ST_RUN) && !clear;
  assign in_chan = sync_in ? '0 : chan_cnt;

  // busy rises one edge after entering CLEAR; writes happen only while busy,
  // which keeps busy high for exactly one cycle per RAM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b0;
    end else if (clear) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else if (state == ST_CLEAR) begin
      if (!busy) begin
        busy <= 1'b1;
      end else if (clr_addr == '1) begin
        state <= ST_RUN;
        busy  <= 1'b0;
      end else begin
        clr_addr <= clr_addr + CHANNEL_ADDR'(1);
      end
    end
  end

  always_comb begin
    ram_we    = s2_valid;
    ram_waddr = s2_chan;
    ram_wdata = {s2_flag, s2_cnt};
    if (state == ST_CLEAR) begin
      ram_we    = busy;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end
  end

  rfi_state_ram #(
    .ADDR_WIDTH (CHANNEL_ADDR),
    .DATA_WIDTH (WORD_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s0_chan),
    .rdata (ram_rdata)
  );

  // thresh is zero-extended so the product is signed x unsigned.
  always_comb begin
    prod = PROD_WIDTH'(s0_pow) * PROD_WIDTH'($signed({1'b0, thresh}));
    lim  = prod >>> THRESH_POINT;
  end

  always_comb begin
    corr_ext = PROD_WIDTH'(s1_corr);
    exceed   = corr_ext > s1_lim;
    old_cnt  = ram_rdata[CNT_WIDTH-1:0];
    old_flag = ram_rdata[CNT_WIDTH];
    cnt_new  = old_cnt;
    if (exceed) begin
      if (old_cnt != '1) begin
        cnt_new = old_cnt + CNT_WIDTH'(1);
      end
    end else if (old_cnt != '0) begin
      cnt_new = old_cnt - CNT_WIDTH'(1);
    end
    new_flag = next_flag(32'(cnt_new), 32'(on_cnt), 32'(off_cnt), old_flag);
  end

  // A channel-0 sample always starts a fresh frame sum, so a sync that
  // truncates a frame discards the partial count.
  always_comb begin
    frame_sum = (s2_chan == '0) ? '0 : acc;
    frame_sum = frame_sum + FC_WIDTH'(s2_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_cnt    <= '0;
      s0_valid    <= 1'b0;
      s0_pow      <= '0;
      s0_corr     <= '0;
      s0_chan     <= '0;
      s1_valid    <= 1'b0;
      s1_lim      <= '0;
      s1_corr     <= '0;
      s1_chan     <= '0;
      s2_valid    <= 1'b0;
      s2_chan     <= '0;
      s2_cnt      <= '0;
      s2_flag     <= 1'b0;
      acc         <= '0;
      flag        <= 1'b0;
      flag_chan   <= '0;
      dout_valid  <= 1'b0;
      frame_count <= '0;
      frame_valid <= 1'b0;
      warning     <= 1'b0;
    end else begin
      warning <= (DEBUG != 0) && din_valid && !accept;

      s0_valid <= accept;
      if (accept) begin
        s0_pow   <= pow_data;
        s0_corr  <= corr_data;
        s0_chan  <= in_chan;
        chan_cnt <= in_chan + CHANNEL_ADDR'(1);
      end

      s1_valid <= s0_valid;
      s1_lim   <= lim;
      s1_corr  <= s0_corr;
      s1_chan  <= s0_chan;

      s2_valid <= s1_valid;
      s2_chan  <= s1_chan;
      s2_cnt   <= cnt_new;
      s2_flag  <= new_flag;

      dout_valid  <= s2_valid;
      frame_valid <= s2_valid && (s2_chan == '1);
      if (s2_valid) begin
        flag      <= s2_flag;
        flag_chan <= s2_chan;
        if (s2_chan == '1) begin
          frame_count <= frame_sum;
          acc         <= '0;
        end else begin
          acc <= frame_sum;
        end
      end

      if (clear) begin
        s0_valid    <= 1'b0;
        s1_valid    <= 1'b0;
        s2_valid    <= 1'b0;
        dout_valid  <= 1'b0;
        frame_valid <= 1'b0;
        chan_cnt    <= '0;
        acc         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rfi_flagger.sv
module tb_rfi_flagger;
  import rfi_flag_pkg::*;

  localparam int DW = 18;
  localparam int CA = 3;
  localparam int TW = 16;
  localparam int TP = 15;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] pow_data;
  logic signed [DW-1:0] corr_data;
  logic                 din_valid;
  logic                 sync_in;
  logic [TW-1:0]        thresh;
  logic [CW-1:0]        on_cnt;
  logic [CW-1:0]        off_cnt;
  logic                 clear;
  logic                 busy;
  logic                 flag;
  logic [CA-1:0]        flag_chan;
  logic                 dout_valid;
  logic [CA:0]          frame_count;
  logic                 frame_valid;
  logic                 warning;

  always #5 clk = ~clk;

  rfi_flagger #(
    .DIN_WIDTH    (DW),
    .CHANNEL_ADDR (CA),
    .THRESH_WIDTH (TW),
    .THRESH_POINT (TP),
    .CNT_WIDTH    (CW),
    .DEBUG        (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pow_data    (pow_data),
    .corr_data   (corr_data),
    .din_valid   (din_valid),
    .sync_in     (sync_in),
    .thresh      (thresh),
    .on_cnt      (on_cnt),
    .off_cnt     (off_cnt),
    .clear       (clear),
    .busy        (busy),
    .flag        (flag),
    .flag_chan   (flag_chan),
    .dout_valid  (dout_valid),
    .frame_count (frame_count),
    .frame_valid (frame_valid),
    .warning     (warning)
  );

  typedef struct {
    int chan;
    int flg;
    int fv;
    int fc;
    int stamp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   n_push   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every dout_valid consumes one expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!dout_valid && frame_valid) begin
      checks++;
      failures++;
      $display("FAIL frame_valid_alone: frame_valid=1 with dout_valid=0, expected 0");
    end
    if (dout_valid) begin
      n_out++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: dout_valid for chan %0d, expected no output", flag_chan);
      end else begin
        e = q.pop_front();
        chk("flag_chan", int'(flag_chan), e.chan);
        chk($sformatf("flag[ch%0d]", e.chan), int'(flag), e.flg);
        chk($sformatf("frame_valid[ch%0d]", e.chan), int'(frame_valid), e.fv);
        if (e.fv != 0) chk("frame_count", int'(frame_count), e.fc);
        chk("latency", cyc - e.stamp, int'(PIPE_LATENCY));
      end
    end
  end

  // Bench data plan: thresh=0.5. Channel 6 uses pow=-1001 (lim=-501 after the
  // arithmetic shift), other channels pow=1000 (lim=500). "hi" corr is lim+1.
  function automatic int low_corr(input int ch);
    case (ch)
      0:       return 500;
      1:       return -500;
      2:       return 499;
      3:       return 0;
      4:       return 500;
      5:       return -131072;
      6:       return -501;
      default: return 500;
    endcase
  endfunction

  task automatic drive(input int ch, input bit hi, input bit sync, input bit expect_out,
                       input bit exp_flag, input bit exp_fv, input int exp_fc);
    exp_t e;
    @(negedge clk);
    if (ch == 6) begin
      pow_data  = 18'(-1001);
      corr_data = hi ? 18'(-500) : 18'(-501);
    end else begin
      pow_data  = 18'(1000);
      corr_data = hi ? 18'(501) : 18'(low_corr(ch));
    end
    din_valid = 1'b1;
    sync_in   = sync;
    if (expect_out) begin
      e.chan  = ch;
      e.flg   = int'(exp_flag);
      e.fv    = int'(exp_fv);
      e.fc    = exp_fc;
      e.stamp = cyc + 1;
      q.push_back(e);
      n_push++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      sync_in   = 1'b0;
    end
  endtask

  // mask: channels that exceed; flags: hand-computed expected flag per channel.
  task automatic frame(input logic [7:0] mask, input logic [7:0] flags, input bit first_sync);
    int fc;
    fc = $countones(flags);
    for (int i = 0; i < 8; i++) begin
      drive(i, mask[i], first_sync && (i == 0), 1'b1, flags[i], i == 7, fc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    rst       = 1'b1;
    pow_data  = '0;
    corr_data = '0;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    thresh    = 16'h4000;
    on_cnt    = 4'd3;
    off_cnt   = 4'd1;
    clear     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_flag", int'(flag), 0);
    chk("rst_flag_chan", int'(flag_chan), 0);
    chk("rst_frame_valid", int'(frame_valid), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_warning", int'(warning), 0);
    rst = 1'b0;

    // Post-reset sweep; an input offered while busy must be dropped.
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (c == 2) din_valid = 1'b1;
      if (c == 3) begin
        din_valid = 1'b0;
        chk("warning_pulse", int'(warning), 1);
      end
      if (c == 4) chk("warning_end", int'(warning), 0);
      if (busy_cycles > 0 && !busy) break;
    end
    chk("reset_busy_cycles", busy_cycles, 8);
    chk("outputs_during_busy", n_out, 0);

    // Hysteresis on channel 2 (on=3, off=1), corr==lim must not count.
    frame(8'h04, 8'h00, 1'b1);
    frame(8'h04, 8'h00, 1'b0);
    frame(8'h04, 8'h04, 1'b0);
    frame(8'h00, 8'h04, 1'b0);
    frame(8'h00, 8'h00, 1'b0);

    // Channels 1,4,7 flagged by the third frame -> frame_count 3.
    frame(8'h92, 8'h00, 1'b0);
    frame(8'h92, 8'h00, 1'b0);
    frame(8'h92, 8'h92, 1'b0);

    // Truncated frame: sync alone is ignored, sync with data restarts at 0.
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    drive(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    din_valid = 1'b0;
    sync_in   = 1'b1;
    drive(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    drive(4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    frame(8'h92, 8'h92, 1'b1);
    idle(6);

    // Clear with two samples in flight: neither may reach the output.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    din_valid = 1'b0;
    clear     = 1'b1;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      clear = 1'b0;
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    chk("clear_busy_cycles", busy_cycles, 8);
    frame(8'h00, 8'h00, 1'b0);

    // Saturation on channel 6 (negative power path).
    for (int f = 1; f <= 20; f++) frame(8'h40, (f >= 3) ? 8'h40 : 8'h00, 1'b0);
    for (int f = 1; f <= 14; f++) frame(8'h00, (f <= 13) ? 8'h40 : 8'h00, 1'b0);
    idle(6);

    // on_cnt <= off_cnt: set rule wins at cnt == 1.
    on_cnt  = 4'd1;
    off_cnt = 4'd1;
    frame(8'h40, 8'h40, 1'b0);
    frame(8'h00, 8'h40, 1'b0);
    idle(8);

    chk("queue_drained", q.size(), 0);
    chk("outputs_total", n_out, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
